// File: rtl/hazard_controller.sv
// hazard_controller: sequencing control for the 5-stage pipeline.
// Handles load-use stalls, taken-branch flushes, memory-wait freezes,
// post-reset clearing and halt-and-drain. It also keeps saturating stall
// and flush performance counters.
module hazard_controller #(
    parameter int BOOT_CYCLES  = 2,
    parameter int DRAIN_CYCLES = 3,
    parameter int TIMEOUT      = 255,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_rd,
    input  logic             mem_branch_taken,
    input  logic             mem_busy,
    input  logic             id_halt,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_flush,
    output logic             pipe_freeze,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int DC_MAX = (BOOT_CYCLES > DRAIN_CYCLES) ? BOOT_CYCLES : DRAIN_CYCLES;
    localparam int DC_W   = $clog2(DC_MAX + 1);
    localparam int BC_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_DRAIN, ST_HALTED} state_t;

    state_t            state;
    logic [DC_W-1:0]   down_cnt;
    logic [BC_W-1:0]   busy_cnt;

    logic luh;
    logic stall_evt;
    logic flush_evt;
    logic halt_evt;

    assign luh = ex_MemRead && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    // Decode pipeline controls from the current state and this cycle's inputs.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_flush = 1'b0;
        pipe_freeze  = 1'b0;
        halted       = 1'b0;
        stall_evt    = 1'b0;
        flush_evt    = 1'b0;
        halt_evt     = 1'b0;
        unique case (state)
            ST_BOOT: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                ex_mem_flush = 1'b1;
            end
            ST_RUN, ST_DRAIN: begin
                if (mem_busy) begin
                    pipe_freeze = 1'b1;
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                end else if (mem_branch_taken) begin
                    // A taken branch in DRAIN means the halt was on the wrong path.
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    ex_mem_flush = 1'b1;
                    flush_evt    = 1'b1;
                end else if (state == ST_DRAIN) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end else if (id_halt) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    halt_evt     = 1'b1;
                end else if (luh) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    stall_evt    = 1'b1;
                end
            end
            ST_HALTED: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                pipe_freeze = 1'b1;
                halted      = 1'b1;
            end
            default: ;
        endcase
    end

    // Advance the FSM, down-counter, busy watchdog and performance counters.
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state       <= ST_BOOT;
            down_cnt    <= DC_W'(BOOT_CYCLES);
            busy_cnt    <= '0;
            mem_timeout <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            unique case (state)
                ST_BOOT: begin
                    down_cnt <= down_cnt - DC_W'(1);
                    if (down_cnt == DC_W'(1)) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (halt_evt) begin
                        state    <= ST_DRAIN;
                        down_cnt <= DC_W'(DRAIN_CYCLES);
                    end
                end
                ST_DRAIN: begin
                    if (!mem_busy) begin
                        if (mem_branch_taken) begin
                            state <= ST_RUN;
                        end else begin
                            down_cnt <= down_cnt - DC_W'(1);
                            if (down_cnt == DC_W'(1)) state <= ST_HALTED;
                        end
                    end
                end
                ST_HALTED: ;
                default: state <= ST_BOOT;
            endcase

            // Consecutive busy cycles are only meaningful while the core runs or drains.
            if (mem_busy && (state == ST_RUN || state == ST_DRAIN)) begin
                if (busy_cnt != BC_W'(TIMEOUT)) busy_cnt <= busy_cnt + BC_W'(1);
                if (busy_cnt >= BC_W'(TIMEOUT - 1)) mem_timeout <= 1'b1;
            end else begin
                busy_cnt <= '0;
            end

            if (stall_evt && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
            if (flush_evt && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed vectors plus hand-written multi-cycle
// sequences for boot, timeout, halt-drain and wrong-path halt.
module tb_hazard_controller;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_MemRead, mem_branch_taken, mem_busy, id_halt;
    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush;
    logic        pipe_freeze, halted, mem_timeout;
    logic [31:0] stall_count, flush_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Output bundle order: pc_write, if_id_write, if_id_flush, id_ex_bubble,
    // ex_mem_flush, pipe_freeze, halted
    localparam logic [6:0] O_RUN    = 7'b1100000;
    localparam logic [6:0] O_BOOT   = 7'b0011100;
    localparam logic [6:0] O_STALL  = 7'b0001000;
    localparam logic [6:0] O_FLUSH  = 7'b1111100;
    localparam logic [6:0] O_FREEZE = 7'b0000010;
    localparam logic [6:0] O_HALTED = 7'b0000011;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       mem_read;
        logic [4:0] rd;
        logic       br;
        logic       busy;
        logic       halt;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs [10];

    hazard_controller #(
        .BOOT_CYCLES(2), .DRAIN_CYCLES(3), .TIMEOUT(255), .CNT_W(32)
    ) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_MemRead(ex_MemRead), .ex_rd(ex_rd),
        .mem_branch_taken(mem_branch_taken), .mem_busy(mem_busy), .id_halt(id_halt),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .ex_mem_flush(ex_mem_flush),
        .pipe_freeze(pipe_freeze), .halted(halted), .mem_timeout(mem_timeout),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [6:0] outs();
        return {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, pipe_freeze, halted};
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    endtask

    // Start a new cycle: inputs change at the falling edge, checks follow 1ns later.
    task automatic cycle(input logic [4:0] rs1, input logic [4:0] rs2, input logic mr,
                         input logic [4:0] rd, input logic br, input logic busy, input logic halt);
        @(negedge clk);
        id_rs1 = rs1; id_rs2 = rs2; ex_MemRead = mr; ex_rd = rd;
        mem_branch_taken = br; mem_busy = busy; id_halt = halt;
        #1;
    endtask

    task automatic idle();
        cycle(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Reset for one edge, then walk through BOOT with mem_busy held high (ignored).
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mem_busy = 1'b1;
        #1;
        check("boot1_outs", 32'(outs()), 32'(O_BOOT));
        check("boot1_stall_cnt", stall_count, 32'd0);
        check("boot1_flush_cnt", flush_count, 32'd0);
        check("boot1_timeout", 32'(mem_timeout), 32'd0);
        cycle(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("boot2_outs", 32'(outs()), 32'(O_BOOT));
        idle();
        check("run1_outs", 32'(outs()), 32'(O_RUN));
        check("run1_counters", stall_count | flush_count, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        id_rs1 = '0; id_rs2 = '0; ex_MemRead = 1'b0; ex_rd = '0;
        mem_branch_taken = 1'b0; mem_busy = 1'b0; id_halt = 1'b0;

        //              rs1    rs2   mr    rd    br    busy  halt  expected
        vecs[0] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_RUN};    // idle
        vecs[1] = '{5'd0, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_STALL};  // luh via rs2
        vecs[2] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_RUN};    // bubble in EX
        vecs[3] = '{5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, O_RUN};    // rd=x0: no stall
        vecs[4] = '{5'd7, 5'd1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, O_STALL};  // luh via rs1
        vecs[5] = '{5'd7, 5'd1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, O_RUN};    // not a load
        vecs[6] = '{5'd3, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, O_FLUSH};  // branch beats luh
        vecs[7] = '{5'd3, 5'd0, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, O_FREEZE}; // busy beats all
        vecs[8] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_RUN};
        vecs[9] = '{5'd9, 5'd9, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, O_FLUSH};  // plain branch

        do_reset();

        // Single-cycle RUN behaviour
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].rs1, vecs[i].rs2, vecs[i].mem_read, vecs[i].rd,
                  vecs[i].br, vecs[i].busy, vecs[i].halt);
            check($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].exp));
        end
        idle();
        check("vec_stall_count", stall_count, 32'd2);
        check("vec_flush_count", flush_count, 32'd2);
        check("vec_timeout", 32'(mem_timeout), 32'd0);

        // Memory timeout: 255 busy cycles, then one more still frozen with the flag up
        for (int i = 1; i <= 255; i++) begin
            cycle(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            check($sformatf("busy%0d", i), {31'd0, mem_timeout, outs()} , {31'd0, 1'b0, O_FREEZE});
        end
        cycle(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("busy256_outs", 32'(outs()), 32'(O_FREEZE));
        check("busy256_timeout", 32'(mem_timeout), 32'd1);
        for (int i = 0; i < 3; i++) begin
            idle();
            check("timeout_sticky", {31'd0, mem_timeout, outs()}, {31'd0, 1'b1, O_RUN});
        end

        // Plain halt-and-drain
        do_reset();
        cycle(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        check("halt_cycle", 32'(outs()), 32'(O_STALL));
        for (int i = 1; i <= 3; i++) begin
            idle();
            check($sformatf("drain%0d", i), 32'(outs()), 32'(O_STALL));
        end
        idle();
        check("halted_reached", 32'(outs()), 32'(O_HALTED));
        cycle(5'd4, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
        check("halted_holds", 32'(outs()), 32'(O_HALTED));
        check("halted_no_flush_count", flush_count, 32'd0);

        // Halt with a 2-cycle busy inside DRAIN
        do_reset();
        cycle(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        check("halt2_cycle", 32'(outs()), 32'(O_STALL));
        idle();
        check("halt2_drain1", 32'(outs()), 32'(O_STALL));
        for (int i = 0; i < 2; i++) begin
            cycle(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            check("halt2_busy", 32'(outs()), 32'(O_FREEZE));
        end
        idle();
        check("halt2_drain2", 32'(outs()), 32'(O_STALL));
        idle();
        check("halt2_drain3", 32'(outs()), 32'(O_STALL));
        idle();
        check("halt2_halted", 32'(outs()), 32'(O_HALTED));

        // Wrong-path halt: branch in the second DRAIN cycle returns to RUN
        do_reset();
        cycle(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        idle();
        check("wp_drain1", 32'(outs()), 32'(O_STALL));
        cycle(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        check("wp_flush", 32'(outs()), 32'(O_FLUSH));
        for (int i = 0; i < 5; i++) begin
            idle();
            check("wp_run", 32'(outs()), 32'(O_RUN));
        end
        check("wp_flush_count", flush_count, 32'd1);

        // Reset taking effect mid-DRAIN
        cycle(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        idle();
        check("mid_drain", 32'(outs()), 32'(O_STALL));
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
